// File: rtl/wb_writer_if.sv
// wb_writer_if: ALU/load inputs, register-file write port and forwarding lookups of the write-back merger.
interface wb_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
);
    logic                       alu_valid;
    logic [ADDR_W-1:0]          alu_rd;
    logic [DATA_W-1:0]          alu_data;
    logic                       ld_valid;
    logic                       ld_ready;
    logic [ADDR_W-1:0]          ld_rd;
    logic [DATA_W-1:0]          ld_data;
    logic                       writereg;
    logic [ADDR_W-1:0]          rd;
    logic [DATA_W-1:0]          writedata;
    logic [ADDR_W-1:0]          fwd_rs1;
    logic [ADDR_W-1:0]          fwd_rs2;
    logic                       fwd1_hit;
    logic [DATA_W-1:0]          fwd1_data;
    logic                       fwd2_hit;
    logic [DATA_W-1:0]          fwd2_data;
    logic [$clog2(DEPTH+1)-1:0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs1, fwd_rs2,
        input  ld_ready, writereg, rd, writedata, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs1, fwd_rs2,
        output ld_ready, writereg, rd, writedata, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending
    );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: merges never-stalled ALU results and FIFO-buffered load results onto one register-file write port.
module wb_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input logic         clock,
    input logic         reset,
    wb_writer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  live;
    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [IW-1:0]     wr_ptr, rd_ptr;
    logic [PW-1:0]     count;
    logic              alu_go, push, pop, head_live;

    assign bus.ld_ready = !reset && (count < PW'(DEPTH));
    assign bus.pending  = count;
    assign alu_go       = bus.alu_valid && bus.alu_rd != '0;
    assign push         = bus.ld_valid && bus.ld_ready && bus.ld_rd != '0;
    assign pop          = !alu_go && count != '0;
    assign head_live    = live[rd_ptr];

    always_ff @(posedge clock)
        if (push) begin
            q_rd[wr_ptr]   <= bus.ld_rd;
            q_data[wr_ptr] <= bus.ld_data;
        end

    // Ordering matters: pop clears the head, ALU kills older matches, then a same-cycle push stays live.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            live          <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.writereg  <= 1'b0;
            bus.rd        <= '0;
            bus.writedata <= '0;
        end else begin
            if (pop) live[rd_ptr] <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                if (alu_go && q_rd[i] == bus.alu_rd) live[i] <= 1'b0;
            if (push) live[wr_ptr] <= 1'b1;
            wr_ptr       <= wr_ptr + IW'(push);
            rd_ptr       <= rd_ptr + IW'(pop);
            count        <= count + PW'(push) - PW'(pop);
            bus.writereg <= alu_go || (pop && head_live);
            if (alu_go) begin
                bus.rd        <= bus.alu_rd;
                bus.writedata <= bus.alu_data;
            end else if (pop && head_live) begin
                bus.rd        <= q_rd[rd_ptr];
                bus.writedata <= q_data[rd_ptr];
            end
        end

    // Scan oldest to youngest so the youngest live match is the one left standing.
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (live[rd_ptr + IW'(k)] && q_rd[rd_ptr + IW'(k)] == bus.fwd_rs1) begin
                bus.fwd1_hit  = 1'b1;
                bus.fwd1_data = q_data[rd_ptr + IW'(k)];
            end
            if (live[rd_ptr + IW'(k)] && q_rd[rd_ptr + IW'(k)] == bus.fwd_rs2) begin
                bus.fwd2_hit  = 1'b1;
                bus.fwd2_data = q_data[rd_ptr + IW'(k)];
            end
        end
    end
endmodule
